// File: rtl/cordic_if.sv
// cordic_if: bundles the start/busy/done handshake, the angle/result datapath
// and the arctangent LUT read port of the CORDIC engine.
// master: upstream datapath plus LUT side; slave: the cordic_core engine.
interface cordic_if #(
   parameter int DATA_WIDTH   = 16,
   parameter int n_iterations = 15
);
   localparam int AW = $clog2(n_iterations);

   logic                         start;
   logic signed [DATA_WIDTH-1:0] angle_in;
   logic                         busy;
   logic                         done;
   logic signed [DATA_WIDTH-1:0] cos_out;
   logic signed [DATA_WIDTH-1:0] sin_out;
   logic [AW-1:0]                lut_raddr;
   logic signed [DATA_WIDTH-1:0] lut_data;

   modport master (
      output start, angle_in, lut_data,
      input  busy, done, cos_out, sin_out, lut_raddr
   );

   modport slave (
      input  start, angle_in, lut_data,
      output busy, done, cos_out, sin_out, lut_raddr
   );
endinterface

// File: rtl/cordic_core.sv
// cordic_core: iterative rotation-mode CORDIC, one micro-rotation per clock.
// Angle in Q3.13 radians, cos/sin out in Q2.14. Reads arctan(2^-i) from an
// external combinational LUT addressed by the iteration index.
// Optional feature: define CORDIC_QUAD_EXT_EN to pre-rotate angles beyond
// +/-pi/2 by pi (and negate the results), extending the domain to +/-pi.
module cordic_core #(
   parameter int DATA_WIDTH   = 16,
   parameter int n_iterations = 15
) (
   input logic     clk,
   input logic     rst,
   cordic_if.slave bus
);
   localparam int AW = $clog2(n_iterations);
   localparam logic signed [DATA_WIDTH-1:0] K_INIT = DATA_WIDTH'(9949);
   localparam logic [AW-1:0] LAST_I = AW'(n_iterations - 1);

   typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

   state_t                       r_state;
   state_t                       w_next;
   logic signed [DATA_WIDTH-1:0] r_x;
   logic signed [DATA_WIDTH-1:0] r_y;
   logic signed [DATA_WIDTH-1:0] r_z;
   logic [AW-1:0]                r_i;
   logic signed [DATA_WIDTH-1:0] r_cos;
   logic signed [DATA_WIDTH-1:0] r_sin;
   logic                         r_done;
   logic signed [DATA_WIDTH-1:0] w_z_init;
   logic                         w_flag;
   logic signed [DATA_WIDTH-1:0] w_xs;
   logic signed [DATA_WIDTH-1:0] w_ys;
   logic                         w_dir_pos;
   logic                         w_accept;

   assign w_accept  = (r_state == IDLE) && bus.start;
   assign w_dir_pos = ~r_z[DATA_WIDTH-1];
   assign w_xs      = r_x >>> r_i;
   assign w_ys      = r_y >>> r_i;

`ifdef CORDIC_QUAD_EXT_EN
   localparam logic signed [DATA_WIDTH-1:0] PI      = DATA_WIDTH'(25736);
   localparam logic signed [DATA_WIDTH-1:0] HALF_PI = DATA_WIDTH'(12868);

   logic w_flag_init;
   logic r_flag;

   // Fold angles outside +/-pi/2 back by pi; the flag remembers to negate.
   always_comb begin
      w_z_init    = bus.angle_in;
      w_flag_init = 1'b0;
      if (bus.angle_in > HALF_PI) begin
         w_z_init    = bus.angle_in - PI;
         w_flag_init = 1'b1;
      end else if (bus.angle_in < -HALF_PI) begin
         w_z_init    = bus.angle_in + PI;
         w_flag_init = 1'b1;
      end
   end

   // Capture the pre-rotation flag with the accepted angle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_flag <= 1'b0;
      else if (w_accept) r_flag <= w_flag_init;
   end

   assign w_flag = r_flag;
`else
   assign w_z_init = bus.angle_in;
   assign w_flag   = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic: IDLE -> ROTATE for n_iterations clocks -> DONE -> IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = ROTATE;
         ROTATE:  if (r_i == LAST_I) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Datapath: load on accept, micro-rotate in ROTATE, publish in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x   <= '0;
         r_y   <= '0;
         r_z   <= '0;
         r_i   <= '0;
         r_cos <= '0;
         r_sin <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_x <= K_INIT;
                  r_y <= '0;
                  r_z <= w_z_init;
                  r_i <= '0;
               end
            end
            ROTATE: begin
               if (w_dir_pos) begin
                  r_x <= r_x - w_ys;
                  r_y <= r_y + w_xs;
                  r_z <= r_z - bus.lut_data;
               end else begin
                  r_x <= r_x + w_ys;
                  r_y <= r_y - w_xs;
                  r_z <= r_z + bus.lut_data;
               end
               r_i <= r_i + AW'(1);
            end
            DONE: begin
               r_cos <= w_flag ? -r_x : r_x;
               r_sin <= w_flag ? -r_y : r_y;
            end
            default: ;
         endcase
      end
   end

   // done pulses for the single cycle after the results are written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_done <= 1'b0;
      else     r_done <= (r_state == DONE);
   end

   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = r_done;
   assign bus.cos_out   = r_cos;
   assign bus.sin_out   = r_sin;
   assign bus.lut_raddr = (r_state == ROTATE) ? r_i : '0;
endmodule

// File: tb/tb_cordic_core.sv
// tb_cordic_core: scoreboard bench for cordic_core. Expected cos/sin values
// (with +/-4 LSB tolerance) are queued when a start is driven and checked
// when done pulses. Define CORDIC_QUAD_EXT_EN to also run the +/-pi cases.
module tb_cordic_core;
   localparam int DW = 16;
   localparam int NI = 15;
   localparam int TOL = 4;

   typedef struct {
      int c;
      int s;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   int   n_vec  = 0;
   int   n_err  = 0;
   int   n_done = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   cordic_if #(.DATA_WIDTH(DW), .n_iterations(NI)) bus ();

   cordic_core #(.DATA_WIDTH(DW), .n_iterations(NI)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // arctan(2^-i) in Q3.13, rounded to nearest
   function automatic logic signed [DW-1:0] atan_lut(input logic [3:0] a);
      case (a)
         4'd0:    return 16'sd6434;
         4'd1:    return 16'sd3798;
         4'd2:    return 16'sd2007;
         4'd3:    return 16'sd1019;
         4'd4:    return 16'sd511;
         4'd5:    return 16'sd256;
         4'd6:    return 16'sd128;
         4'd7:    return 16'sd64;
         4'd8:    return 16'sd32;
         4'd9:    return 16'sd16;
         4'd10:   return 16'sd8;
         4'd11:   return 16'sd4;
         4'd12:   return 16'sd2;
         4'd13:   return 16'sd1;
         default: return 16'sd0;
      endcase
   endfunction

   assign bus.lut_data = atan_lut(bus.lut_raddr);

   function automatic bit near(input int a, input int b);
      return ((a - b) <= TOL) && ((b - a) <= TOL);
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      exp_t e;
      if (bus.done === 1'b1) begin
         n_done++;
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_unexpected: done pulsed with no outstanding request");
         end else begin
            e = sb.pop_front();
            n_vec++;
            if (!near(int'(bus.cos_out), e.c)) begin
               n_err++;
               $display("FAIL cos_out: got %0d want %0d+/-%0d", int'(bus.cos_out), e.c, TOL);
            end
            n_vec++;
            if (!near(int'(bus.sin_out), e.s)) begin
               n_err++;
               $display("FAIL sin_out: got %0d want %0d+/-%0d", int'(bus.sin_out), e.s, TOL);
            end
         end
      end
   end

   // Starts a conversion at the current negedge and waits for its done.
   // ign_at > 0 pulses a second (to-be-ignored) start that many cycles in.
   task automatic do_conv(input int ang, input int ec, input int es,
                          input bit chk_addr, input int ign_at, input int ign_ang);
      int cyc;
      bit seen;
      exp_t e;
      e.c = ec;
      e.s = es;
      bus.angle_in = DW'(ang);
      bus.start    = 1'b1;
      sb.push_back(e);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) bus.start = 1'b0;
         if (ign_at > 0 && cyc == ign_at) begin
            bus.start    = 1'b1;
            bus.angle_in = DW'(ign_ang);
         end
         if (ign_at > 0 && cyc == ign_at + 1) bus.start = 1'b0;
         if (cyc == 1) begin
            n_vec++;
            if (bus.busy !== 1'b1) begin
               n_err++;
               $display("FAIL busy_after_accept: got %b want 1", bus.busy);
            end
         end
         if (chk_addr && cyc <= NI) begin
            n_vec++;
            if (bus.lut_raddr !== 4'(cyc - 1)) begin
               n_err++;
               $display("FAIL lut_raddr cycle %0d: got %0d want %0d", cyc, bus.lut_raddr, cyc - 1);
            end
         end
         if (bus.done === 1'b1) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL done_timeout: got no done in %0d cycles, want one at cycle 17", cyc);
         void'(sb.pop_back());
      end else if (cyc != 17) begin
         n_err++;
         $display("FAIL latency: got done at cycle %0d want 17", cyc);
      end
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL busy_in_done_cycle: got %b want 0", bus.busy);
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.angle_in = '0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.lut_raddr !== 4'd0) begin
         n_err++;
         $display("FAIL reset_ctrl: got busy=%b done=%b raddr=%0d want 0/0/0",
                  bus.busy, bus.done, bus.lut_raddr);
      end
      n_vec++;
      if (bus.cos_out !== 16'sd0 || bus.sin_out !== 16'sd0) begin
         n_err++;
         $display("FAIL reset_data: got cos=%0d sin=%0d want 0/0", bus.cos_out, bus.sin_out);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_angles();
      do_conv(0, 16384, 0, 1'b0, 0, 0);
      @(negedge clk);
      do_conv(4289, 14189, 8192, 1'b0, 0, 0);
      @(negedge clk);
      do_conv(-6434, 11585, -11585, 1'b1, 0, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_start_ignored();
      int d0;
      d0 = n_done;
      do_conv(-4289, 14189, -8192, 1'b0, 5, 6434);
      repeat (20) @(negedge clk);
      n_vec++;
      if (n_done - d0 != 1) begin
         n_err++;
         $display("FAIL ignored_start_pulses: got %0d done pulses want 1", n_done - d0);
      end
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL ignored_start_busy: got %b want 0", bus.busy);
      end
   endtask

   task automatic test_abort();
      int d0;
      exp_t e;
      e.c = 14189;
      e.s = 8192;
      bus.angle_in = 16'sd4289;
      bus.start    = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      #1;
      void'(sb.pop_back());
      d0 = n_done;
      n_vec++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.lut_raddr !== 4'd0) begin
         n_err++;
         $display("FAIL abort_ctrl: got busy=%b done=%b raddr=%0d want 0/0/0",
                  bus.busy, bus.done, bus.lut_raddr);
      end
      n_vec++;
      if (bus.cos_out !== 16'sd0 || bus.sin_out !== 16'sd0) begin
         n_err++;
         $display("FAIL abort_data: got cos=%0d sin=%0d want 0/0", bus.cos_out, bus.sin_out);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      n_vec++;
      if (n_done != d0) begin
         n_err++;
         $display("FAIL abort_done: got %0d done pulses want 0", n_done - d0);
      end
      do_conv(0, 16384, 0, 1'b0, 0, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      do_conv(6434, 11585, 11585, 1'b0, 0, 0);
      do_conv(-4289, 14189, -8192, 1'b0, 0, 0);
      do_conv(12868, 0, 16384, 1'b0, 0, 0);
      repeat (2) @(negedge clk);
   endtask

`ifdef CORDIC_QUAD_EXT_EN
   task automatic test_quad_ext();
      do_conv(25736, -16384, 0, 1'b0, 0, 0);
      @(negedge clk);
      do_conv(-19302, -11585, -11585, 1'b0, 0, 0);
      @(negedge clk);
      do_conv(19302, -11585, 11585, 1'b0, 0, 0);
      repeat (2) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_angles();
      test_start_ignored();
      test_abort();
      test_back_to_back();
`ifdef CORDIC_QUAD_EXT_EN
      test_quad_ext();
`endif
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d outstanding want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
